button_event_ctrl: RTL and testbench

Scans a bank of bouncy push-button inputs on a shared millisecond-scale tick and debounces each one with a per-button stable-count rule. It turns level changes into press, release and optional auto-repeat events, and queues those events in a small FIFO with a valid/ready output port. It sits between the board button pins and the front-panel/UI logic, replacing per-button debounce instances with one shared scheduler.

---
 rtl/button_event_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_button_event_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_ctrl.sv
// button_event_ctrl: shared-scan push-button debouncer feeding a press/release event FIFO.
// Define BTN_REPEAT_EN to compile in auto-repeat counters and repeat events.
module button_event_ctrl #(
  parameter int N_BUTTONS    = 4,
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 8,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_BUTTONS-1:0]         btn_in,
  output logic [N_BUTTONS-1:0]         btn_level,
  output logic                         evt_valid,
  input  logic                         evt_ready,
  output logic [$clog2(N_BUTTONS)-1:0] evt_code,
  output logic [1:0]                   evt_kind,
  output logic                         overflow,
  input  logic                         clr_overflow
);

  localparam int CW = $clog2(N_BUTTONS);
  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = $clog2(STABLE_TICKS);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int QW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {ST_IDLE, ST_SCAN} state_t;
  typedef enum logic [1:0] {
    KIND_PRESS   = 2'b00,
    KIND_RELEASE = 2'b01,
    KIND_REPEAT  = 2'b10
  } kind_t;

  logic [N_BUTTONS-1:0] sync1, sync2;
  logic [DW-1:0]        div;
  logic                 tick;
  state_t               state, state_nx;
  logic [CW-1:0]        idx, idx_nx;
  logic [SW-1:0]        cnt [N_BUTTONS];
  logic [SW-1:0]        cnt_nx;
  logic                 s, lvl, accept;
  logic                 push;
  kind_t                push_kind;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
    end
  end

  assign tick = (div == DW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || tick) div <= '0;
    else             div <= div + DW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    case (state)
      ST_IDLE: if (tick) begin
        state_nx = ST_SCAN;
        idx_nx   = '0;
      end
      ST_SCAN: begin
        if (idx == CW'(N_BUTTONS - 1)) state_nx = ST_IDLE;
        else                           idx_nx   = idx + CW'(1);
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    s      = sync2[idx];
    lvl    = btn_level[idx];
    accept = 1'b0;
    cnt_nx = '0;
    if (s != lvl) begin
      if (cnt[idx] == SW'(STABLE_TICKS - 1)) accept = 1'b1;
      else                                   cnt_nx = cnt[idx] + SW'(1);
    end
  end

`ifdef BTN_REPEAT_EN
  localparam int RW = (REPEAT_DELAY > 1) ? $clog2(REPEAT_DELAY) : 1;
  logic [RW-1:0] rep [N_BUTTONS];
  logic [RW-1:0] rep_nx;
  logic          rep_fire;

  always_comb begin
    push      = (state == ST_SCAN) && accept;
    push_kind = s ? KIND_PRESS : KIND_RELEASE;
    rep_nx    = rep[idx];
    rep_fire  = 1'b0;
    // a release freezes rep; it is reloaded by the next press
    if (accept) begin
      if (s) rep_nx = '0;
    end else if (lvl) begin
      if (rep[idx] == RW'(REPEAT_DELAY - 1)) begin
        rep_fire = 1'b1;
        rep_nx   = RW'(REPEAT_DELAY - REPEAT_RATE);
      end else begin
        rep_nx = rep[idx] + RW'(1);
      end
    end
    if ((state == ST_SCAN) && rep_fire) begin
      push      = 1'b1;
      push_kind = KIND_REPEAT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_BUTTONS; i++) rep[i] <= '0;
    end else if (state == ST_SCAN) begin
      rep[idx] <= rep_nx;
    end
  end
`else
  localparam int unused_repeat_cfg = REPEAT_DELAY + REPEAT_RATE;

  always_comb begin
    push      = (state == ST_SCAN) && accept;
    push_kind = s ? KIND_PRESS : KIND_RELEASE;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_level <= '0;
      for (int unsigned i = 0; i < N_BUTTONS; i++) cnt[i] <= '0;
    end else if (state == ST_SCAN) begin
      cnt[idx] <= cnt_nx;
      if (accept) btn_level[idx] <= s;
    end
  end

  logic [CW-1:0] mem_code [FIFO_DEPTH];
  logic [1:0]    mem_kind [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [QW-1:0] count;
  logic          pop, full, do_push, drop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign evt_valid = (count != '0);
  assign pop       = evt_valid && evt_ready;
  assign full      = (count == QW'(FIFO_DEPTH));
  // a pop in the same cycle frees the slot the push needs
  assign do_push   = push && (!full || pop);
  assign drop      = push && full && !pop;
  assign evt_code  = mem_code[rd_ptr];
  assign evt_kind  = mem_kind[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)     rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, pop})
        2'b10:   count <= count + QW'(1);
        2'b01:   count <= count - QW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_code[wr_ptr] <= idx;
      mem_kind[wr_ptr] <= push_kind;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)               overflow <= 1'b0;
    else if (drop)         overflow <= 1'b1;
    else if (clr_overflow) overflow <= 1'b0;
  end

endmodule

// File: tb/tb_button_event_ctrl.sv
// Scoreboard bench for button_event_ctrl: a scan-level reference model queues expected events,
// a negedge monitor compares the DUT event port, levels and overflow against it.
module tb_button_event_ctrl;

  localparam int N  = 4;
  localparam int TD = 8;
  localparam int ST = 3;
  localparam int RD = 4;
  localparam int RR = 2;
  localparam int FD = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] btn_in;
  logic [N-1:0] btn_level;
  logic         evt_valid;
  logic         evt_ready;
  logic [1:0]   evt_code;
  logic [1:0]   evt_kind;
  logic         overflow;
  logic         clr_overflow;

  always #5 clk = ~clk;

  button_event_ctrl #(
    .N_BUTTONS    (N),
    .TICK_DIV     (TD),
    .STABLE_TICKS (ST),
    .REPEAT_DELAY (RD),
    .REPEAT_RATE  (RR),
    .FIFO_DEPTH   (FD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_in       (btn_in),
    .btn_level    (btn_level),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_code     (evt_code),
    .evt_kind     (evt_kind),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  typedef struct packed {
    logic [1:0] code;
    logic [1:0] kind;
  } evt_t;

  evt_t         exp_q[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  bit           chk_en = 1'b0;
  logic [N-1:0] m_lvl, in_d1, in_d2, m_s;
  int           run [N];
`ifdef BTN_REPEAT_EN
  int           since [N];
`endif
  bit           m_ovf, m_ev, m_pop, m_drop;
  evt_t         m_e;
  int           bi;

  // Reference model: button i is sampled at cycles TD+i, 2*TD+i, ... after reset release,
  // seeing the input level from two cycles earlier.
  always @(posedge clk) begin
    if (rst) begin
      cyc    = 0;
      m_lvl  = '0;
      in_d1  = '0;
      in_d2  = '0;
      m_ovf  = 1'b0;
      exp_q.delete();
      for (int i = 0; i < N; i++) begin
        run[i] = 0;
`ifdef BTN_REPEAT_EN
        since[i] = 0;
`endif
      end
      chk_en = 1'b1;
    end else begin
      m_s   = in_d2;
      in_d2 = in_d1;
      in_d1 = btn_in;
      m_ev  = 1'b0;
      m_e   = '0;
      if (cyc >= TD && ((cyc - TD) % TD) < N) begin
        bi = (cyc - TD) % TD;
        if (m_s[bi] != m_lvl[bi]) begin
          run[bi]++;
          if (run[bi] == ST) begin
            m_lvl[bi] = m_s[bi];
            run[bi]   = 0;
            m_ev      = 1'b1;
            m_e.code  = 2'(bi);
            m_e.kind  = m_s[bi] ? 2'b00 : 2'b01;
`ifdef BTN_REPEAT_EN
            if (m_s[bi]) since[bi] = 0;
`endif
          end
        end else begin
          run[bi] = 0;
        end
`ifdef BTN_REPEAT_EN
        if (!m_ev && m_lvl[bi]) begin
          since[bi]++;
          if (since[bi] == RD || (since[bi] > RD && ((since[bi] - RD) % RR) == 0)) begin
            m_ev     = 1'b1;
            m_e.code = 2'(bi);
            m_e.kind = 2'b10;
          end
        end
`endif
      end
      m_pop  = (exp_q.size() > 0) && evt_ready;
      m_drop = 1'b0;
      if (m_pop) void'(exp_q.pop_front());
      if (m_ev) begin
        if (exp_q.size() < FD) exp_q.push_back(m_e);
        else                   m_drop = 1'b1;
      end
      if (m_drop)            m_ovf = 1'b1;
      else if (clr_overflow) m_ovf = 1'b0;
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (evt_valid !== (exp_q.size() != 0)) begin
        errors++;
        $display("FAIL evt_valid actual=%b required=%b cyc=%0d", evt_valid, exp_q.size() != 0, cyc);
      end else if (evt_valid) begin
        checks++;
        if (evt_code !== exp_q[0].code || evt_kind !== exp_q[0].kind) begin
          errors++;
          $display("FAIL event actual code=%0d kind=%b required code=%0d kind=%b cyc=%0d",
                   evt_code, evt_kind, exp_q[0].code, exp_q[0].kind, cyc);
        end
      end
      checks++;
      if (btn_level !== m_lvl) begin
        errors++;
        $display("FAIL btn_level actual=%b required=%b cyc=%0d", btn_level, m_lvl, cyc);
      end
      checks++;
      if (overflow !== m_ovf) begin
        errors++;
        $display("FAIL overflow actual=%b required=%b cyc=%0d", overflow, m_ovf, cyc);
      end
    end
  end

  // Returns at the negedge of a cycle in which button p is being scanned.
  task automatic sync_scan(input int p);
    for (int k = 0; k < 4 * TD; k++) begin
      @(negedge clk);
      if (cyc >= TD && ((cyc - TD) % TD) == p) break;
    end
  endtask

  int b, d;

  initial begin
    rst          = 1'b1;
    btn_in       = '0;
    evt_ready    = 1'b1;
    clr_overflow = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    btn_in = 4'b0100;
    repeat (60) @(negedge clk);
    btn_in = '0;
    repeat (50) @(negedge clk);

    for (int k = 0; k < 12; k++) begin
      btn_in[1] = ~btn_in[1];
      repeat (5) @(negedge clk);
    end
    btn_in[1] = 1'b0;
    repeat (40) @(negedge clk);

    btn_in[0] = 1'b1;
    repeat (100) @(negedge clk);
    btn_in[0] = 1'b0;
    repeat (40) @(negedge clk);

    evt_ready = 1'b0;
    btn_in    = 4'b1111;
    repeat (48) @(negedge clk);
    btn_in[0] = 1'b0;
    repeat (40) @(negedge clk);
    clr_overflow = 1'b1;
    @(negedge clk);
    clr_overflow = 1'b0;
    repeat (3) @(negedge clk);

    // release of btn 1 lands exactly 3 scans later, in the single cycle evt_ready is high
    sync_scan(1);
    btn_in[1] = 1'b0;
    repeat (3 * TD) @(negedge clk);
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
    repeat (4) @(negedge clk);
    evt_ready = 1'b1;
    repeat (60) @(negedge clk);
    btn_in = '0;
    repeat (60) @(negedge clk);

    for (int it = 0; it < 80; it++) begin
      b = $urandom_range(0, N - 1);
      d = $urandom_range(1, 40);
      btn_in[b] = ~btn_in[b];
      for (int c = 0; c < d; c++) begin
        evt_ready    = ($urandom_range(0, 3) != 0);
        clr_overflow = ($urandom_range(0, 31) == 0);
        @(negedge clk);
      end
    end
    evt_ready    = 1'b1;
    clr_overflow = 1'b0;
    btn_in       = '0;
    repeat (60) @(negedge clk);

    evt_ready = 1'b0;
    btn_in    = 4'b1001;
    repeat (40) @(negedge clk);
    sync_scan(1);
    rst = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    evt_ready = 1'b1;
    repeat (60) @(negedge clk);
    btn_in = '0;
    repeat (40) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
